controle_seq: RTL
=================

// Module: controle_seq
// PURPOSE
//  Parametrised multi-cycle successor of the calculator control unit. Accepts 3-bit
//  opcodes over a valid/ready handshake and drives registered control words
//  (tx, ty, tz, tula) to the X/Y/Z registers and ULA, one word per clock.
//  SHIFTR repeats for SHIFT_N cycles. Reports busy/done and flags illegal opcodes.
// PARAMETERS
//  SEL_W    4  width of tx/ty/tz; codes zero-extended to SEL_W
//  ULA_W    4  width of tula; codes zero-extended to ULA_W
//  SHIFT_N  1  SHIFTR repeat count, legal 1..15; step counter is 4 bits
// PORTS
//  clock     in   1      single clock, rising edge
//  reset     in   1      asynchronous, active-high
//  op_valid  in   1      op is presented
//  op        in   3      opcode
//  op_ready  out  1      block accepts op this cycle
//  tx        out  SEL_W  X register select
//  ty        out  SEL_W  Y register select
//  tz        out  SEL_W  Z register select
//  tula      out  ULA_W  ULA function: 0=add, 1=shift right
//  busy      out  1      opcode in execution
//  done      out  1      final word of the current op is on the outputs
//  err       out  1      one-cycle pulse: illegal opcode consumed
// BEHAVIOUR
//  - Reset: tx=ty=tz=0, tula=0, busy=0, done=0, err=0, state IDLE, step=0. Applies
//    immediately, including mid-op. The in-flight op is dropped with no done.
//  - Handshake: transfer on the edge where op_valid & op_ready. op_ready is 1 only
//    in IDLE. op must be stable while op_valid=1 and op_ready=0.
//  - Word table (tx,ty,tz,tula):
//    000 CLEARLD 1,0,0,0 | 001 ADDLD 1,1,2,0 | 010 ADD 0,1,2,0
//    011 SHIFTR  2,3,2,1 | 100 DISPLAY 2,0,1,0
//    NOP = 0,0,0,0 (hold).
//  - Op length: 1 word, except SHIFTR, which is SHIFT_N identical words.
//  - Latency: the first word is registered on the transfer edge and visible the
//    next cycle. Words then follow one per cycle. done=1 is coincident with the
//    last word. busy=1 from the first word through the last word.
//  - FSM:
//    IDLE -> EXEC on a legal transfer.
//    EXEC stays put while step < len-1 (step++).
//    At the last step, the next edge loads NOP and returns to IDLE.
//    Base build: at least one NOP/IDLE cycle between consecutive ops.
//  - Illegal op (101..111): consumed; err=1 for the following cycle; outputs stay
//    NOP; busy=0; stays in IDLE.
//  - op_valid=1 in IDLE with no change: ops are accepted back-to-back per the
//    rules above. No op is ever lost or duplicated.
// CONFIGURATION
//  - CONTROLE_QUEUE_EN defined:
//    - Adds a one-entry op buffer. op_ready = IDLE | (EXEC & buffer empty).
//    - A legal op accepted during EXEC is stored. On the last-step edge, its first
//      word loads directly (no NOP gap); busy stays 1; done still pulses with each
//      op's last word.
//    - An illegal op accepted during EXEC sets err for the next cycle and is not
//      buffered.
//    - Reset clears the buffer.
//  - CONTROLE_QUEUE_EN undefined: no buffer, base behaviour above.
// TESTING
//  1. Reset asserted mid-SHIFTR (SHIFT_N=4, step 2): outputs 0 at once; busy=0;
//     no done; op_ready=1 after release.
//  2. op=000, one-cycle valid: next cycle tx=1, ty=0, tz=0, done=1, busy=1; the
//     following cycle is all 0 and op_ready=1.
//  3. SHIFT_N=3, op=011: three cycles of 2,3,2,1; done only on the third; then NOP.
//  4. op=110: err=1 for one cycle; tx..tula stay 0; busy=0; a next op=010 gives
//     0,1,2,0.
//  5. Ops 001,010,100 held valid back-to-back (base build): words
//     1,1,2 / NOP / 0,1,2 / NOP / 2,0,1, with 3 done pulses.
//  6. CONTROLE_QUEUE_EN, same stream as test 5: words contiguous, with no NOP cycles
//     until after 2,0,1; op_ready low while the buffer is full.

Source files
------------

// File: rtl/controle_seq_if.sv
// rtl/controle_seq_if.sv - opcode handshake and control-word bundle for controle_seq
interface controle_seq_if #(
    parameter int SEL_W = 4,
    parameter int ULA_W = 4
);
    logic             op_valid;
    logic [2:0]       op;
    logic             op_ready;
    logic [SEL_W-1:0] tx;
    logic [SEL_W-1:0] ty;
    logic [SEL_W-1:0] tz;
    logic [ULA_W-1:0] tula;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output op_valid, op,
        input  op_ready, tx, ty, tz, tula, busy, done, err
    );

    modport slave (
        input  op_valid, op,
        output op_ready, tx, ty, tz, tula, busy, done, err
    );
endinterface

// File: rtl/controle_seq.sv
// rtl/controle_seq.sv - multi-cycle calculator control sequencer with registered control words
// Optional one-entry op buffer for gapless back-to-back ops: CONTROLE_QUEUE_EN.
module controle_seq #(
    parameter int SEL_W   = 4,
    parameter int ULA_W   = 4,
    parameter int SHIFT_N = 1
) (
    input  logic          clock,
    input  logic          reset,
    controle_seq_if.slave bus
);
    localparam int WORD_W = 3 * SEL_W + ULA_W;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t              state, state_n;
    logic [3:0]          step, step_n;
    logic [3:0]          last, last_n;
    logic [WORD_W-1:0]   word, word_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic                err_q, err_n;
    logic                xfer;
    logic                legal;
`ifdef CONTROLE_QUEUE_EN
    logic                bufv, bufv_n;
    logic [2:0]          bufop, bufop_n;
`endif

    function automatic logic [WORD_W-1:0] word_of(input logic [2:0] o);
        logic [SEL_W-1:0] x, y, z;
        logic [ULA_W-1:0] u;
        x = '0;
        y = '0;
        z = '0;
        u = '0;
        case (o)
            3'b000: x = SEL_W'(1);
            3'b001: begin x = SEL_W'(1); y = SEL_W'(1); z = SEL_W'(2); end
            3'b010: begin y = SEL_W'(1); z = SEL_W'(2); end
            3'b011: begin x = SEL_W'(2); y = SEL_W'(3); z = SEL_W'(2); u = ULA_W'(1); end
            3'b100: begin x = SEL_W'(2); z = SEL_W'(1); end
            default: ;
        endcase
        return {x, y, z, u};
    endfunction

    // Index of the final step: SHIFTR repeats, everything else is a single word.
    function automatic logic [3:0] last_of(input logic [2:0] o);
        return (o == 3'b011) ? 4'(SHIFT_N - 1) : 4'd0;
    endfunction

`ifdef CONTROLE_QUEUE_EN
    assign bus.op_ready = (state == IDLE) || !bufv;
`else
    assign bus.op_ready = (state == IDLE);
`endif

    assign xfer  = bus.op_valid && bus.op_ready;
    assign legal = (bus.op <= 3'b100);

    always_comb begin
        state_n = state;
        step_n  = step;
        last_n  = last;
        word_n  = word;
        busy_n  = busy_q;
        done_n  = done_q;
        err_n   = 1'b0;
`ifdef CONTROLE_QUEUE_EN
        bufv_n  = bufv;
        bufop_n = bufop;
`endif
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (legal) begin
                        state_n = EXEC;
                        step_n  = 4'd0;
                        last_n  = last_of(bus.op);
                        word_n  = word_of(bus.op);
                        busy_n  = 1'b1;
                        done_n  = (last_of(bus.op) == 4'd0);
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            EXEC: begin
`ifdef CONTROLE_QUEUE_EN
                if (xfer) begin
                    if (legal) begin
                        bufv_n  = 1'b1;
                        bufop_n = bus.op;
                    end else begin
                        err_n = 1'b1;
                    end
                end
`endif
                if (step != last) begin
                    step_n = step + 4'd1;
                    done_n = ((step + 4'd1) == last);
                end else begin
`ifdef CONTROLE_QUEUE_EN
                    // An op taken on this very edge chains straight in as well.
                    if (bufv_n) begin
                        step_n = 4'd0;
                        last_n = last_of(bufop_n);
                        word_n = word_of(bufop_n);
                        done_n = (last_of(bufop_n) == 4'd0);
                        bufv_n = 1'b0;
                    end else
`endif
                    begin
                        state_n = IDLE;
                        step_n  = 4'd0;
                        word_n  = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            step   <= 4'd0;
            last   <= 4'd0;
            word   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef CONTROLE_QUEUE_EN
            bufv   <= 1'b0;
            bufop  <= 3'b000;
`endif
        end else begin
            state  <= state_n;
            step   <= step_n;
            last   <= last_n;
            word   <= word_n;
            busy_q <= busy_n;
            done_q <= done_n;
            err_q  <= err_n;
`ifdef CONTROLE_QUEUE_EN
            bufv   <= bufv_n;
            bufop  <= bufop_n;
`endif
        end
    end

    assign bus.tx   = word[WORD_W-1 -: SEL_W];
    assign bus.ty   = word[WORD_W-SEL_W-1 -: SEL_W];
    assign bus.tz   = word[ULA_W +: SEL_W];
    assign bus.tula = word[ULA_W-1:0];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule
